// File: rtl/tx_burst_counters.sv
// Bit counter and burst counter for the I2C transmit controller.
// TXCount counts a level enable; BurstCnt counts rising edges of IncBurstCnt.
module tx_burst_counters #(
  parameter int TX_WIDTH    = 6,
  parameter int BURST_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ResetTXCount,
  input  logic                   IncTXCount,
  output logic [TX_WIDTH-1:0]    TXCount,
  input  logic                   ResetBurstCnt,
  input  logic                   IncBurstCnt,
  output logic [BURST_WIDTH-1:0] BurstCnt
);

  localparam logic [TX_WIDTH-1:0]    TX_ONE    = {{(TX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [BURST_WIDTH-1:0] BURST_ONE = {{(BURST_WIDTH-1){1'b0}}, 1'b1};

  logic inc_q;
  logic burst_edge;

  assign burst_edge = IncBurstCnt & ~inc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      TXCount <= '0;
    end else if (ResetTXCount) begin
      TXCount <= '0;
    end else if (IncTXCount) begin
      TXCount <= TXCount + TX_ONE;
    end
  end

  // inc_q tracks IncBurstCnt even while the burst counter is held in clear,
  // so a pulse that straddles ResetBurstCnt is never counted afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inc_q    <= 1'b0;
      BurstCnt <= '0;
    end else begin
      inc_q <= IncBurstCnt;
      if (ResetBurstCnt) begin
        BurstCnt <= '0;
      end else if (burst_edge) begin
        BurstCnt <= BurstCnt + BURST_ONE;
      end
    end
  end

endmodule

// File: tb/tb_tx_burst_counters.sv
// Randomized and directed bench for tx_burst_counters, checked against a
// pulse-counting reference model plus literal expectations.
module tb_tx_burst_counters;

  localparam int TW = 6;
  localparam int BW = 6;
  localparam int TMOD = 1 << TW;
  localparam int BMOD = 1 << BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ResetTXCount = 1'b0;
  logic          IncTXCount = 1'b0;
  logic          ResetBurstCnt = 1'b0;
  logic          IncBurstCnt = 1'b0;
  logic [TW-1:0] TXCount;
  logic [BW-1:0] BurstCnt;

  int  nchk = 0;
  int  nerr = 0;
  bit  check_en = 1'b0;

  int  m_tx = 0;
  int  m_bursts = 0;
  bit  m_level = 1'b0;

  tx_burst_counters #(.TX_WIDTH(TW), .BURST_WIDTH(BW)) dut (
    .clk(clk),
    .rst(rst),
    .ResetTXCount(ResetTXCount),
    .IncTXCount(IncTXCount),
    .TXCount(TXCount),
    .ResetBurstCnt(ResetBurstCnt),
    .IncBurstCnt(IncBurstCnt),
    .BurstCnt(BurstCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: TX is a modular position count; bursts are counted as the
  // number of high pulses that begin while no burst clear is in force.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tx     <= 0;
      m_bursts <= 0;
      m_level  <= 1'b0;
    end else begin
      m_tx <= ResetTXCount ? 0 : (IncTXCount ? (m_tx + 1) % TMOD : m_tx);
      if (ResetBurstCnt)
        m_bursts <= 0;
      else if (IncBurstCnt && !m_level)
        m_bursts <= (m_bursts + 1) % BMOD;
      m_level <= IncBurstCnt;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_tx", {26'd0, TXCount}, m_tx);
      chk("model_burst", {26'd0, BurstCnt}, m_bursts);
    end
  end

  task automatic tick(input bit rt, input bit it, input bit rb, input bit ib);
    @(negedge clk);
    ResetTXCount  = rt;
    IncTXCount    = it;
    ResetBurstCnt = rb;
    IncBurstCnt   = ib;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #12;
    chk("reset_tx", {26'd0, TXCount}, 0);
    chk("reset_burst", {26'd0, BurstCnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;

    // Clear then 16 increments: one step per edge, then hold.
    tick(1, 0, 1, 0);
    for (int i = 0; i < 16; i++) begin
      tick(0, 1, 0, 0);
      chk("tx_step", {26'd0, TXCount}, i + 1);
    end
    tick(0, 0, 0, 0);
    chk("tx_hold16", {26'd0, TXCount}, 16);

    // Clear wins over increment, then wrap after 64 increments.
    tick(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick(0, 1, 0, 0);
    chk("tx_at9", {26'd0, TXCount}, 9);
    tick(1, 1, 0, 0);
    chk("tx_clr_prio", {26'd0, TXCount}, 0);
    for (int i = 0; i < 63; i++) tick(0, 1, 0, 0);
    chk("tx_at63", {26'd0, TXCount}, 63);
    tick(0, 1, 0, 0);
    chk("tx_wrap", {26'd0, TXCount}, 0);

    // Held-high pulse counts once; second pulse counts once more.
    tick(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 1);
      chk("burst_held", {26'd0, BurstCnt}, 1);
    end
    for (int i = 0; i < 2; i++) begin
      tick(0, 0, 0, 0);
      chk("burst_low", {26'd0, BurstCnt}, 1);
    end
    tick(0, 0, 0, 1);
    chk("burst_second", {26'd0, BurstCnt}, 2);
    tick(0, 0, 0, 0);
    chk("burst_hold2", {26'd0, BurstCnt}, 2);

    // Clear coincident with a rising edge discards it; staying high adds nothing.
    tick(0, 0, 1, 1);
    chk("burst_clr_edge", {26'd0, BurstCnt}, 0);
    tick(0, 0, 0, 1);
    chk("burst_no_new_edge", {26'd0, BurstCnt}, 0);
    tick(0, 0, 0, 0);

    // Counters are independent.
    tick(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 0, (i >= 3 && i < 6));
      chk("mix_tx", {26'd0, TXCount}, i + 1);
    end
    chk("mix_burst", {26'd0, BurstCnt}, 1);

    // Async reset mid-count clears before the next edge.
    tick(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) tick(0, 1, 0, (i == 0));
    chk("pre_rst_tx", {26'd0, TXCount}, 5);
    chk("pre_rst_burst", {26'd0, BurstCnt}, 1);
    @(negedge clk);
    IncTXCount = 1'b0;
    IncBurstCnt = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("async_tx", {26'd0, TXCount}, 0);
    chk("async_burst", {26'd0, BurstCnt}, 0);
    #1 rst = 1'b0;
    tick(0, 0, 0, 0);
    chk("post_rst_tx", {26'd0, TXCount}, 0);
    chk("post_rst_burst", {26'd0, BurstCnt}, 0);

    // A level already high when reset releases counts once.
    @(negedge clk);
    IncBurstCnt = 1'b1;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_release_high", {26'd0, BurstCnt}, 1);
    tick(0, 0, 0, 1);
    chk("rst_release_hold", {26'd0, BurstCnt}, 1);

    // Random traffic against the model, with occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      bit ib;
      ib = ($urandom_range(3) == 0) ? ~IncBurstCnt : IncBurstCnt;
      tick($urandom_range(7) == 0, $urandom_range(1) == 1,
           $urandom_range(31) == 0, ib);
      if ($urandom_range(499) == 0) begin
        @(negedge clk);
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    check_en = 1'b0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/tx_burst_counters.md
# tx_burst_counters

Counter pair for the I2C transmit path's double-buffered controller. It holds the bit counter (`TXCount`) and the burst counter (`BurstCnt`). The controller FSM drives the reset and increment strobes for both counters and reads the counts back to choose its next state. Both counters are registered on one clock, share one asynchronous reset, and use no arithmetic beyond 6-bit increment with wrap-around.

## Interface
Parameters:
- `TX_WIDTH`, default 6: width of `TXCount`.
- `BURST_WIDTH`, default 6: width of `BurstCnt`.

Ports:
- `clk` input 1: single clock, rising-edge active.
- `rst` input 1: one clock; reset is asynchronous and active-high.
- `ResetTXCount` input 1: synchronous clear of `TXCount`.
- `IncTXCount` input 1: level increment enable for `TXCount`.
- `TXCount` output `TX_WIDTH`: registered bit/byte position counter.
- `ResetBurstCnt` input 1: synchronous clear of `BurstCnt`.
- `IncBurstCnt` input 1: burst-complete strobe, counted on its rising edge.
- `BurstCnt` output `BURST_WIDTH`: registered count of completed bursts.

## Operation
- `rst` high clears `TXCount`, `BurstCnt` and the internal `IncBurstCnt` history register to 0 immediately, without waiting for a clock edge.
- TX counter, evaluated at each rising `clk`:
  - If `ResetTXCount`=1, `TXCount` becomes 0. Reset has priority over increment when both are high.
  - Else if `IncTXCount`=1, `TXCount` becomes `TXCount`+1 modulo 2^`TX_WIDTH`, so 63 wraps to 0.
  - Otherwise `TXCount` holds.
  - `IncTXCount` is a level input: holding it high for N cycles adds N.
- Burst counter, evaluated at each rising `clk`:
  - The register `inc_q` stores the previous sample of `IncBurstCnt` and updates on every clock, including during `ResetBurstCnt`.
  - Edge condition: `IncBurstCnt`=1 and `inc_q`=0.
  - If `ResetBurstCnt`=1, `BurstCnt` becomes 0 and any coincident edge is discarded.
  - Else if the edge condition holds, `BurstCnt` becomes `BurstCnt`+1 modulo 2^`BURST_WIDTH`.
  - Otherwise `BurstCnt` holds.
  - The controller may hold `IncBurstCnt` high for many cycles. A high pulse of any length counts exactly once.
- Because `inc_q` resets to 0, an `IncBurstCnt` that is already high when `rst` deasserts counts once at the first clock edge.
- The two counters are fully independent. Simultaneous activity on both behaves as each counter alone.
- There is no saturation, overflow flag or terminal-count output. The controller compares against its own thresholds (8-bit address, 16-bit data, burst limit 2).

## Timing
- All outputs are flops with no combinational path from any input to any output.
- Latency: a strobe sampled high at edge k is reflected on the output immediately after edge k, and is visible to the controller at edge k+1.
- Edge detection adds no extra latency: the rising edge of `IncBurstCnt` is sampled at edge k and `BurstCnt` updates at edge k.
- Inputs are synchronous to `clk`. No synchronizers are included.
- If `rst` asserts mid-operation, both counters clear immediately. Counting resumes at the first clock edge after `rst` deasserts.
- Sequence used by the controller:
  - `ResetTXCount`=1 for one cycle, then `IncTXCount`=1 for 7 cycles, yields `TXCount`=7 seven edges later.
  - `ResetTXCount`=1 together with `IncTXCount`=1 yields 0.

## Test plan
- Apply `rst` pulse mid-count with `TXCount`=5 and `BurstCnt`=1 -> both read 0 immediately, before the next clock edge, and stay 0 until strobed.
- `ResetTXCount`=1 for 1 cycle, then `IncTXCount`=1 for 16 cycles -> `TXCount` steps 1..16, one per edge, and holds at 16 once `IncTXCount`=0.
- `ResetTXCount`=1 and `IncTXCount`=1 together with `TXCount`=9 -> `TXCount`=0. Then 64 increment cycles -> `TXCount` wraps 63 to 0.
- `IncBurstCnt` high for 5 cycles, low for 2, high for 1 -> `BurstCnt` goes 0 to 1 on the first edge and 1 to 2 on the second pulse, and never changes during the held-high cycles.
- `ResetBurstCnt`=1 on the same edge as an `IncBurstCnt` rising edge, with `BurstCnt`=2 -> `BurstCnt`=0 and no count is taken. If `IncBurstCnt` stays high after reset releases -> still 0, because there is no new edge.
- Interleave `IncTXCount`=1 continuously with an `IncBurstCnt` pulse -> `TXCount` increments every cycle undisturbed and `BurstCnt` increments once.
